controle_somador: RTL and testbench

Sequencer for the team's 4-bit adder display datapath on the DE2 board. It captures operand A, then operand B plus carry-in, from the slide switches, one debounced push-button press per step. It computes the 5-bit sum, holds it, and drives it in decimal on two 7-segment displays until the user restarts. It replaces free-running combinational operand entry with a stepped, registered flow.

---
 rtl/somador_pkg.sv | 28 ++
 rtl/decodificador.sv | 27 ++
 rtl/detector_borda.sv | 56 +++++
 rtl/controle_somador.sv | 131 +++++++++++++
 tb/tb_controle_somador.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/somador_pkg.sv
// Shared definitions for the stepped 4-bit adder: FSM encoding, operand
// widths and the active-low 7-segment patterns used by decodificador.
package somador_pkg;

  localparam int OP_W   = 4;
  localparam int SOMA_W = OP_W + 1;

  // One-hot so the state register can drive the LEDR indicator directly
  typedef enum logic [3:0] {
    ESP_A  = 4'b0001,
    ESP_B  = 4'b0010,
    CALC   = 4'b0100,
    MOSTRA = 4'b1000
  } estado_t;

  localparam logic [0:6] SEG_0 = 7'b0000001;
  localparam logic [0:6] SEG_1 = 7'b1001111;
  localparam logic [0:6] SEG_2 = 7'b0010010;
  localparam logic [0:6] SEG_3 = 7'b0000110;
  localparam logic [0:6] SEG_4 = 7'b1001100;
  localparam logic [0:6] SEG_5 = 7'b0100100;
  localparam logic [0:6] SEG_6 = 7'b0100000;
  localparam logic [0:6] SEG_7 = 7'b0001111;
  localparam logic [0:6] SEG_8 = 7'b0000000;
  localparam logic [0:6] SEG_9 = 7'b0000100;
  localparam logic [0:6] SEG_APAGADO = 7'b1111111;

endpackage

// File: rtl/decodificador.sv
// BCD digit to active-low 7-segment pattern, segments a..g in [0:6] order.
// Codes 10-15 blank the display.
module decodificador
  import somador_pkg::*;
(
  input  logic [3:0] digito,
  output logic [0:6] seg
);

  always_comb begin
    seg = SEG_APAGADO;
    case (digito)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_APAGADO;
    endcase
  end

endmodule

// File: rtl/detector_borda.sv
// Conditions the raw "enter" key: 2-FF synchronizer, stability debounce and
// a single-cycle pulse on each accepted press.
module detector_borda #(
  parameter int DEB_CYCLES = 1000
) (
  input  logic CLOCK_50,
  input  logic RESETn,
  input  logic KEY_N,
  output logic enter
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    sinc;
  logic          tecla_estavel;
  logic          tecla_anterior;
  logic [CW-1:0] contador;

  // Synchronizer idles at 1 so reset looks like a released key
  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      sinc <= 2'b11;
    end else begin
      sinc <= {sinc[0], KEY_N};
    end
  end

  // Any sample equal to the accepted level restarts the count, so a bounce
  // shorter than DEB_CYCLES never changes tecla_estavel
  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      tecla_estavel <= 1'b1;
      contador      <= '0;
    end else if (sinc[1] != tecla_estavel) begin
      if (contador == CW'(DEB_CYCLES - 1)) begin
        tecla_estavel <= sinc[1];
        contador      <= '0;
      end else begin
        contador <= contador + 1'b1;
      end
    end else begin
      contador <= '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      tecla_anterior <= 1'b1;
      enter          <= 1'b0;
    end else begin
      tecla_anterior <= tecla_estavel;
      enter          <= tecla_anterior & ~tecla_estavel;
    end
  end

endmodule

// File: rtl/controle_somador.sv
// Stepped operand entry for the DE2 4-bit adder: A, then B with carry-in,
// one press each; the 5-bit sum is shown in decimal until the next press.
module controle_somador
  import somador_pkg::*;
#(
  parameter int DEB_CYCLES = 1000
) (
  input  logic            CLOCK_50,
  input  logic            RESETn,
  input  logic [OP_W-1:0] SW,
  input  logic            TE,
  input  logic            KEY_N,
  output logic [0:6]      HEX0,
  output logic [0:6]      HEX1,
  output logic [4:0]      LEDR,
  output logic            LEDG
);

  logic              enter;
  estado_t           estado;
  estado_t           estado_prox;
  logic [OP_W-1:0]   reg_a;
  logic [OP_W-1:0]   reg_b;
  logic              reg_te;
  logic [SOMA_W-1:0] soma;
  logic [SOMA_W-1:0] valor;
  logic [3:0]        unidade;
  logic [3:0]        dezena;
  logic [0:6]        seg_uni;
  logic [0:6]        seg_dez;

  detector_borda #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_detector (
    .CLOCK_50(CLOCK_50),
    .RESETn  (RESETn),
    .KEY_N   (KEY_N),
    .enter   (enter)
  );

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      estado <= ESP_A;
    end else begin
      estado <= estado_prox;
    end
  end

  // CALC ignores enter, so a press landing there is simply lost
  always_comb begin
    estado_prox = estado;
    case (estado)
      ESP_A:   if (enter) estado_prox = ESP_B;
      ESP_B:   if (enter) estado_prox = CALC;
      CALC:    estado_prox = MOSTRA;
      MOSTRA:  if (enter) estado_prox = ESP_A;
      default: estado_prox = ESP_A;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      reg_a  <= '0;
      reg_b  <= '0;
      reg_te <= 1'b0;
      soma   <= '0;
    end else begin
      case (estado)
        ESP_A: begin
          if (enter) begin
            reg_a <= SW;
          end
        end
        ESP_B: begin
          if (enter) begin
            reg_b  <= SW;
            reg_te <= TE;
          end
        end
        CALC: begin
          soma <= {1'b0, reg_a} + {1'b0, reg_b} + {{OP_W{1'b0}}, reg_te};
        end
        MOSTRA: begin
          if (enter) begin
            reg_a  <= '0;
            reg_b  <= '0;
            reg_te <= 1'b0;
            soma   <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Operand entry shows the live switches; afterwards the held sum
  always_comb begin
    valor = soma;
    if (estado == ESP_A || estado == ESP_B) begin
      valor = {1'b0, SW};
    end
    unidade = 4'(valor % SOMA_W'(10));
    dezena  = 4'(valor / SOMA_W'(10));
  end

  decodificador u_dec_uni (
    .digito(unidade),
    .seg   (seg_uni)
  );

  decodificador u_dec_dez (
    .digito(dezena),
    .seg   (seg_dez)
  );

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      HEX0 <= SEG_0;
      HEX1 <= SEG_0;
      LEDR <= {1'b0, ESP_A};
      LEDG <= 1'b0;
    end else begin
      HEX0 <= seg_uni;
      HEX1 <= seg_dez;
      LEDR <= {1'b0, estado};
      LEDG <= (estado == CALC || estado == MOSTRA) && (soma > SOMA_W'(15));
    end
  end

endmodule

// File: tb/tb_controle_somador.sv
// Randomized bench for controle_somador against a press-level model of the
// A / B / sum / restart sequence and its decimal display.
module tb_controle_somador;

  logic       CLOCK_50 = 1'b0;
  logic       RESETn;
  logic [3:0] SW;
  logic       TE;
  logic       KEY_N;
  logic [0:6] HEX0;
  logic [0:6] HEX1;
  logic [4:0] LEDR;
  logic       LEDG;

  int assert_count = 0;
  int fail_count   = 0;
  int enter_count  = 0;

  int m_state;
  int m_a;
  int m_b;
  int m_te;
  int m_soma;

  logic [6:0] seg_ref [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

  controle_somador #(
    .DEB_CYCLES(4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESETn  (RESETn),
    .SW      (SW),
    .TE      (TE),
    .KEY_N   (KEY_N),
    .HEX0    (HEX0),
    .HEX1    (HEX1),
    .LEDR    (LEDR),
    .LEDG    (LEDG)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (dut.u_detector.enter === 1'b1) enter_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // m_state: 0 = waiting A, 1 = waiting B, 3 = showing the sum
  task automatic modelReset();
    m_state = 0;
    m_a = 0;
    m_b = 0;
    m_te = 0;
    m_soma = 0;
  endtask

  task automatic modelEnter();
    case (m_state)
      0: begin m_a = int'(SW); m_state = 1; end
      1: begin m_b = int'(SW); m_te = int'(TE); m_soma = m_a + m_b + m_te; m_state = 3; end
      default: begin modelReset(); end
    endcase
  endtask

  task automatic checkDisplay(input string tag);
    int v;
    v = (m_state < 2) ? int'(SW) : m_soma;
    checkOutput({tag, "_hex0"}, 32'(HEX0), 32'(seg_ref[v % 10]));
    checkOutput({tag, "_hex1"}, 32'(HEX1), 32'(seg_ref[v / 10]));
    checkOutput({tag, "_ledr"}, 32'(LEDR), 32'(1 << m_state));
    checkOutput({tag, "_ledg"}, 32'(LEDG), 32'((m_state == 3 && m_soma > 15) ? 1 : 0));
  endtask

  task automatic applyStimulus(input int hold);
    KEY_N = 1'b0;
    repeat (hold) @(negedge CLOCK_50);
    KEY_N = 1'b1;
    repeat (15) @(negedge CLOCK_50);
  endtask

  task automatic press();
    modelEnter();
    applyStimulus(15);
  endtask

  task automatic runSum(input int a, input int b, input int te);
    SW = 4'(a);
    press();
    checkDisplay("esp_b");
    SW = 4'(b);
    TE = 1'(te);
    press();
    checkDisplay("mostra");
    SW = 4'($urandom_range(0, 15));
    repeat (3) @(negedge CLOCK_50);
    checkDisplay("mostra_hold");
    press();
    SW = 4'($urandom_range(0, 15));
    repeat (3) @(negedge CLOCK_50);
    checkDisplay("restart");
  endtask

  initial begin
    int c0;
    RESETn = 1'b0;
    KEY_N  = 1'b1;
    SW     = 4'd0;
    TE     = 1'b0;
    modelReset();
    repeat (3) @(negedge CLOCK_50);
    checkOutput("reset_hex0", 32'(HEX0), 32'h01);
    checkOutput("reset_hex1", 32'(HEX1), 32'h01);
    checkOutput("reset_ledr", 32'(LEDR), 32'h01);
    checkOutput("reset_ledg", 32'(LEDG), 32'h0);
    RESETn = 1'b1;
    SW = 4'd13;
    repeat (3) @(negedge CLOCK_50);
    checkDisplay("idle_sw");

    runSum(7, 5, 0);
    runSum(15, 15, 1);
    runSum(3, 4, 1);
    for (int i = 0; i < 8; i++) begin
      runSum($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
    end

    // Bounce shorter than the debounce window, then a solid press
    SW = 4'd9;
    c0 = enter_count;
    for (int i = 0; i < 5; i++) begin
      KEY_N = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      KEY_N = 1'b1;
      repeat (2) @(negedge CLOCK_50);
    end
    checkOutput("bounce_nopulse", 32'(enter_count - c0), 32'd0);
    modelEnter();
    KEY_N = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    KEY_N = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    checkOutput("bounce_pulses", 32'(enter_count - c0), 32'd1);
    checkDisplay("bounce");
    SW = 4'd1;
    TE = 1'b0;
    press();
    checkDisplay("bounce_sum");
    press();

    // Long hold: one advance, operand frozen at pulse time
    SW = 4'd9;
    c0 = enter_count;
    modelEnter();
    KEY_N = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    SW = 4'd2;
    repeat (180) @(negedge CLOCK_50);
    KEY_N = 1'b1;
    repeat (15) @(negedge CLOCK_50);
    checkOutput("held_pulses", 32'(enter_count - c0), 32'd1);
    checkDisplay("held");
    SW = 4'd4;
    TE = 1'b0;
    press();
    checkDisplay("held_sum");

    // Asynchronous reset in MOSTRA with the key held through it
    @(negedge CLOCK_50);
    #3;
    RESETn = 1'b0;
    KEY_N  = 1'b0;
    #1;
    checkOutput("areset_hex0", 32'(HEX0), 32'h01);
    checkOutput("areset_hex1", 32'(HEX1), 32'h01);
    checkOutput("areset_ledr", 32'(LEDR), 32'h01);
    checkOutput("areset_ledg", 32'(LEDG), 32'h0);
    modelReset();
    repeat (5) @(negedge CLOCK_50);
    SW = 4'd11;
    c0 = enter_count;
    RESETn = 1'b1;
    modelEnter();
    repeat (15) @(negedge CLOCK_50);
    KEY_N = 1'b1;
    repeat (15) @(negedge CLOCK_50);
    checkOutput("reset_held_pulses", 32'(enter_count - c0), 32'd1);
    checkDisplay("reset_held");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
